// File: rtl/axil_puf_pkg.sv
// Shared definitions for the AXI4-Lite PUF controller: register map, STATUS
// bit positions, AXI response codes and the evaluation FSM state type.
package axil_puf_pkg;

   localparam logic [31:0] REG_VERSION    = 32'h00;
   localparam logic [31:0] REG_SCRATCH    = 32'h04;
   localparam logic [31:0] REG_CONTROL    = 32'h08;
   localparam logic [31:0] REG_STATUS     = 32'h0C;
   localparam logic [31:0] REG_CHALLENGE  = 32'h10;
   localparam logic [31:0] REG_RESPONSE   = 32'h14;
   localparam logic [31:0] REG_EVAL_COUNT = 32'h18;

   localparam int unsigned STAT_BUSY    = 0;
   localparam int unsigned STAT_DONE    = 1;
   localparam int unsigned STAT_TIMEOUT = 2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      IDLE,
      WAIT
   } puf_state_t;

   function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int unsigned b = 0; b < 4; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/axil_puf_seq.sv
// PUF evaluation sequencer: issues the start pulse, holds the challenge and
// watches for completion or timeout.
module axil_puf_seq
   import axil_puf_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_req,
   input  logic [31:0] challenge,
   input  logic        puf_done,
   output logic [31:0] puf_challenge,
   output logic        puf_start,
   output logic        busy,
   output logic        done_evt,
   output logic        timeout_evt
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   puf_state_t       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [31:0]      chal_n;
   logic             start_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         puf_challenge <= '0;
         puf_start     <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         puf_challenge <= chal_n;
         puf_start     <= start_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      chal_n      = puf_challenge;
      start_n     = 1'b0;
      done_evt    = 1'b0;
      timeout_evt = 1'b0;
      case (state)
         IDLE: begin
            if (start_req) begin
               state_n = WAIT;
               cnt_n   = '0;
               chal_n  = challenge;
               start_n = 1'b1;
            end
         end
         WAIT: begin
            // A done strobe on the last counted cycle still counts as success.
            if (puf_done) begin
               done_evt = 1'b1;
               state_n  = IDLE;
            end else if (cnt == CNT_LAST) begin
               timeout_evt = 1'b1;
               state_n     = IDLE;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state == WAIT);

endmodule

// File: rtl/axil_puf_ctrl.sv
// AXI4-Lite register front end for a single PUF core: register file, write
// and read channel handling, and the evaluation sequencer instance.
module axil_puf_ctrl
   import axil_puf_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 5,
   parameter logic [31:0] VERSION        = 32'h0001_0000,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  s_axi_aclk,
   input  logic                  s_axi_areset,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [31:0]           s_axi_wdata,
   input  logic [3:0]            s_axi_wstrb,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [31:0]           s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic [31:0]           puf_challenge,
   output logic                  puf_start,
   input  logic                  puf_done,
   input  logic [31:0]           puf_response
);

   logic                  ready_en;
   logic                  aw_full, w_full;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [31:0]           w_data_q;
   logic [3:0]            w_strb_q;

   logic [31:0] scratch, challenge, response, eval_count;
   logic        done_flag, timeout_flag;

   logic        busy, done_evt, timeout_evt;
   logic        aw_hs, w_hs, ar_hs, wr_fire, wr_ok;
   logic [31:0] wr_off, wr_word, rd_off, rd_val;
   logic        wr_err;
   logic [1:0]  rd_resp;
   logic        wr_scratch, wr_challenge, start_req, clr_done, clr_timeout;

   // Readies come up one cycle after reset releases and close while a
   // response is pending.
   assign s_axi_awready = ready_en & ~aw_full & ~s_axi_bvalid;
   assign s_axi_wready  = ready_en & ~w_full & ~s_axi_bvalid;
   assign s_axi_arready = ready_en & ~s_axi_rvalid;

   assign aw_hs   = s_axi_awvalid & s_axi_awready;
   assign w_hs    = s_axi_wvalid & s_axi_wready;
   assign ar_hs   = s_axi_arvalid & s_axi_arready;
   assign wr_fire = aw_full & w_full;

   always_comb begin
      wr_off       = 32'(aw_addr_q);
      wr_word      = {wr_off[31:2], 2'b00};
      wr_err       = (wr_off > REG_EVAL_COUNT);
      wr_ok        = wr_fire & ~wr_err;
      wr_scratch   = wr_ok & (wr_word == REG_SCRATCH);
      wr_challenge = wr_ok & (wr_word == REG_CHALLENGE);
      start_req    = wr_ok & (wr_word == REG_CONTROL) & w_strb_q[0] & w_data_q[0];
      clr_done     = wr_ok & (wr_word == REG_STATUS) & w_strb_q[0] & w_data_q[STAT_DONE];
      clr_timeout  = wr_ok & (wr_word == REG_STATUS) & w_strb_q[0] & w_data_q[STAT_TIMEOUT];
   end

   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         ready_en     <= 1'b0;
         aw_full      <= 1'b0;
         w_full       <= 1'b0;
         aw_addr_q    <= '0;
         w_data_q     <= '0;
         w_strb_q     <= '0;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= RESP_OKAY;
      end else begin
         ready_en <= 1'b1;
         if (aw_hs) begin
            aw_full   <= 1'b1;
            aw_addr_q <= s_axi_awaddr;
         end
         if (w_hs) begin
            w_full   <= 1'b1;
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
         end
         if (wr_fire) begin
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
         end else if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         scratch      <= '0;
         challenge    <= '0;
         response     <= '0;
         eval_count   <= '0;
         done_flag    <= 1'b0;
         timeout_flag <= 1'b0;
      end else begin
         if (wr_scratch)   scratch   <= apply_strb(scratch, w_data_q, w_strb_q);
         if (wr_challenge) challenge <= apply_strb(challenge, w_data_q, w_strb_q);
         if (done_evt) begin
            response   <= puf_response;
            eval_count <= eval_count + 32'd1;
         end
         // Hardware set takes priority over a coincident software clear.
         if (done_evt)         done_flag <= 1'b1;
         else if (clr_done)    done_flag <= 1'b0;
         if (timeout_evt)      timeout_flag <= 1'b1;
         else if (clr_timeout) timeout_flag <= 1'b0;
      end
   end

   always_comb begin
      rd_off  = 32'(s_axi_araddr);
      rd_val  = '0;
      rd_resp = RESP_OKAY;
      if (rd_off > REG_EVAL_COUNT) begin
         rd_resp = RESP_SLVERR;
      end else begin
         case ({rd_off[31:2], 2'b00})
            REG_VERSION:    rd_val = VERSION;
            REG_SCRATCH:    rd_val = scratch;
            REG_STATUS: begin
               rd_val[STAT_BUSY]    = busy;
               rd_val[STAT_DONE]    = done_flag;
               rd_val[STAT_TIMEOUT] = timeout_flag;
            end
            REG_CHALLENGE:  rd_val = challenge;
            REG_RESPONSE:   rd_val = response;
            REG_EVAL_COUNT: rd_val = eval_count;
            default:        rd_val = '0;
         endcase
      end
   end

   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         s_axi_rvalid <= 1'b0;
         s_axi_rdata  <= '0;
         s_axi_rresp  <= RESP_OKAY;
      end else if (ar_hs) begin
         s_axi_rvalid <= 1'b1;
         s_axi_rdata  <= rd_val;
         s_axi_rresp  <= rd_resp;
      end else if (s_axi_rvalid && s_axi_rready) begin
         s_axi_rvalid <= 1'b0;
      end
   end

   axil_puf_seq #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_seq (
      .clk          (s_axi_aclk),
      .rst          (s_axi_areset),
      .start_req    (start_req),
      .challenge    (challenge),
      .puf_done     (puf_done),
      .puf_challenge(puf_challenge),
      .puf_start    (puf_start),
      .busy         (busy),
      .done_evt     (done_evt),
      .timeout_evt  (timeout_evt)
   );

endmodule

// File: tb/tb_axil_puf_ctrl.sv
// Bench for axil_puf_ctrl: AXI-Lite master tasks, a behavioural PUF core and
// a register-level reference model.
module tb_axil_puf_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  awaddr, araddr;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic [31:0] puf_challenge, puf_response;
   logic        puf_start, puf_done;

   always #5 clk = ~clk;

   axil_puf_ctrl #(
      .ADDR_WIDTH(5),
      .VERSION(32'h0001_0000),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .s_axi_aclk(clk), .s_axi_areset(rst),
      .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .puf_challenge(puf_challenge), .puf_start(puf_start),
      .puf_done(puf_done), .puf_response(puf_response)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model of the software-visible registers
   logic [31:0] m_scratch, m_chal, m_resp, m_count;
   logic        m_done, m_to, m_busy;

   // Behavioural PUF core
   int          puf_mode  = 0;
   int          puf_delay = 0;
   logic [31:0] puf_val   = '0;
   int          countdown = 0;
   int          start_cnt = 0;
   int          stray_req = 0;
   int          stray_srv = 0;
   logic [31:0] seen_chal = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] nv,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = nv[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] a);
      if (a > 5'h18) return 32'h0;
      case (a[4:2])
         3'd0:    return 32'h0001_0000;
         3'd1:    return m_scratch;
         3'd3:    return {29'b0, m_to, m_done, m_busy};
         3'd4:    return m_chal;
         3'd5:    return m_resp;
         3'd6:    return m_count;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [1:0] model_resp(input logic [4:0] a);
      return (a > 5'h18) ? 2'b10 : 2'b00;
   endfunction

   task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      if (a > 5'h18) return;
      case (a[4:2])
         3'd1: m_scratch = merge(m_scratch, d, s);
         3'd3: begin
            if (s[0] && d[1]) m_done = 1'b0;
            if (s[0] && d[2]) m_to   = 1'b0;
         end
         3'd4: m_chal = merge(m_chal, d, s);
         default: ;
      endcase
   endtask

   task automatic model_reset();
      m_scratch = '0; m_chal = '0; m_resp = '0; m_count = '0;
      m_done = 1'b0; m_to = 1'b0; m_busy = 1'b0;
   endtask

   initial begin
      puf_done = 1'b0;
      puf_response = '0;
      forever begin
         @(negedge clk);
         puf_done = 1'b0;
         puf_response = $urandom;
         if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
               puf_done = 1'b1;
               puf_response = puf_val;
            end
         end else if (stray_req != stray_srv) begin
            stray_srv++;
            puf_done = 1'b1;
         end
         if (puf_start) begin
            start_cnt++;
            seen_chal = puf_challenge;
            if (puf_mode == 1) countdown = puf_delay;
         end
      end
   end

   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, output logic [1:0] resp);
      int ga, gw, gb;
      ga = 0; gw = 0; gb = 0;
      @(negedge clk);
      fork
         begin
            repeat (aw_dly) @(negedge clk);
            awaddr = a; awvalid = 1'b1;
            while (!awready && ga < 40) begin @(negedge clk); ga++; end
            check("awready", {31'b0, awready}, 32'd1);
            @(posedge clk); #1 awvalid = 1'b0;
         end
         begin
            repeat (w_dly) @(negedge clk);
            wdata = d; wstrb = s; wvalid = 1'b1;
            while (!wready && gw < 40) begin @(negedge clk); gw++; end
            check("wready", {31'b0, wready}, 32'd1);
            @(posedge clk); #1 wvalid = 1'b0;
         end
      join
      bready = 1'b1;
      while (!bvalid && gb < 40) begin @(negedge clk); gb++; end
      check("bvalid", {31'b0, bvalid}, 32'd1);
      resp = bresp;
      @(posedge clk); #1 bready = 1'b0;
      @(negedge clk);
      check("bvalid_clear", {31'b0, bvalid}, 32'd0);
   endtask

   task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
      int g;
      g = 0;
      @(negedge clk);
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      while (!arready && g < 40) begin @(negedge clk); g++; end
      check("arready", {31'b0, arready}, 32'd1);
      @(posedge clk); #1 arvalid = 1'b0;
      check("rvalid_latency", {31'b0, rvalid}, 32'd1);
      g = 0;
      while (!rvalid && g < 40) begin @(negedge clk); g++; end
      d = rdata; resp = rresp;
      @(posedge clk); #1 rready = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [4:0] a);
      logic [31:0] d;
      logic [1:0]  r;
      axi_read(a, d, r);
      check({tag, "_data"}, d, model_read(a));
      check({tag, "_resp"}, {30'b0, r}, {30'b0, model_resp(a)});
   endtask

   task automatic write_check(input string tag, input logic [4:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int aw_dly, input int w_dly);
      logic [1:0] r;
      axi_write(a, d, s, aw_dly, w_dly, r);
      check({tag, "_bresp"}, {30'b0, r}, {30'b0, model_resp(a)});
      model_write(a, d, s);
   endtask

   task automatic do_eval(input string tag, input logic [31:0] chal, input logic [31:0] val,
                          input int dly);
      int s0;
      write_check({tag, "_chal"}, 5'h10, chal, 4'hF, 0, 0);
      puf_mode = 1; puf_val = val; puf_delay = dly; s0 = start_cnt;
      write_check({tag, "_start"}, 5'h08, 32'h1, 4'h1, $urandom_range(0, 2), $urandom_range(0, 2));
      if (dly >= 10) begin
         m_busy = 1'b1;
         read_check({tag, "_busy"}, 5'h0C);
         m_busy = 1'b0;
      end
      repeat (dly + 4) @(negedge clk);
      check({tag, "_starts"}, 32'(start_cnt - s0), 32'd1);
      check({tag, "_puf_chal"}, seen_chal, chal);
      m_resp = val; m_done = 1'b1; m_count = m_count + 32'd1;
      read_check({tag, "_status"}, 5'h0C);
      read_check({tag, "_response"}, 5'h14);
      read_check({tag, "_count"}, 5'h18);
      write_check({tag, "_w1c"}, 5'h0C, 32'h2, 4'h1, 0, 0);
   endtask

   initial begin
      logic [4:0]  a;
      logic [31:0] d;
      int          s0;
      int          sel;
      rst = 1'b1;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arvalid = 1'b0; rready = 1'b0;
      model_reset();
      repeat (4) @(negedge clk);
      check("rst_ready", {29'b0, awready, wready, arready}, 32'd0);
      check("rst_valid", {29'b0, bvalid, rvalid, puf_start}, 32'd0);
      check("rst_data", rdata, 32'd0);
      check("rst_resp", {28'b0, bresp, rresp}, 32'd0);
      check("rst_chal", puf_challenge, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_rise", {29'b0, awready, wready, arready}, 32'd7);

      read_check("version", 5'h00);
      read_check("scratch0", 5'h04);
      read_check("status0", 5'h0C);
      read_check("count0", 5'h18);
      read_check("response0", 5'h14);

      write_check("scratch_strb", 5'h04, 32'hDEAD_BEEF, 4'b0011, 0, 3);
      read_check("scratch_rb", 5'h04);
      check("scratch_value", m_scratch, 32'h0000_BEEF);

      for (int i = 0; i < 16; i++) begin
         sel = $urandom_range(0, 3);
         case (sel)
            0: a = 5'h04;
            1: a = 5'h10;
            2: a = 5'(32'h19 + $urandom_range(0, 6));
            default: a = 5'(4 * $urandom_range(0, 6));
         endcase
         if (a == 5'h08) a = 5'h04;
         write_check("rand_wr", a, $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 3));
         read_check("rand_rb", 5'(4 * $urandom_range(0, 7)));
         read_check("rand_rb_tgt", a);
      end

      do_eval("eval1", 32'h1234_5678, 32'hCAFE_F00D, 10);

      // Stray done strobe while idle must not disturb anything.
      stray_req++;
      repeat (4) @(negedge clk);
      read_check("stray_status", 5'h0C);
      read_check("stray_resp", 5'h14);
      read_check("stray_count", 5'h18);

      // Timeout: core never answers.
      puf_mode = 0; s0 = start_cnt;
      write_check("to_start", 5'h08, 32'h1, 4'h1, 0, 0);
      m_busy = 1'b1;
      read_check("to_busy", 5'h0C);
      m_busy = 1'b0;
      repeat (20) @(negedge clk);
      m_to = 1'b1;
      read_check("to_status", 5'h0C);
      read_check("to_resp", 5'h14);
      read_check("to_count", 5'h18);
      write_check("to_w1c", 5'h0C, 32'h4, 4'h1, 0, 0);
      read_check("to_cleared", 5'h0C);
      check("to_starts", 32'(start_cnt - s0), 32'd1);

      // START while busy, challenge rewrite while busy, out-of-range read.
      s0 = start_cnt;
      d = m_chal;
      write_check("busy_start1", 5'h08, 32'h1, 4'h1, 0, 0);
      write_check("busy_start2", 5'h08, 32'h1, 4'h1, 0, 0);
      write_check("busy_chal", 5'h10, 32'hA5A5_5A5A, 4'hF, 0, 0);
      check("busy_puf_chal", puf_challenge, d);
      read_check("bad_addr", 5'h1C);
      repeat (20) @(negedge clk);
      check("busy_starts", 32'(start_cnt - s0), 32'd1);
      m_to = 1'b1;
      read_check("busy_to_status", 5'h0C);
      read_check("busy_chal_rb", 5'h10);
      write_check("busy_w1c", 5'h0C, 32'h6, 4'h1, 0, 0);

      for (int i = 0; i < 4; i++) do_eval("eval_rand", $urandom, $urandom, $urandom_range(1, 12));

      // Counter wrap
      @(negedge clk);
      force dut.eval_count = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.eval_count;
      m_count = 32'hFFFF_FFFF;
      read_check("preload", 5'h18);
      do_eval("wrap", 32'h0BAD_F00D, 32'h1357_9BDF, 5);
      check("wrap_value", m_count, 32'h0);

      // Reset in the middle of an evaluation.
      puf_mode = 0;
      write_check("rst_scratch", 5'h04, 32'h7777_7777, 4'hF, 0, 0);
      write_check("rst_start", 5'h08, 32'h1, 4'h1, 0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst_outs", {29'b0, bvalid, rvalid, puf_start}, 32'd0);
      check("midrst_chal", puf_challenge, 32'd0);
      rst = 1'b0;
      model_reset();
      read_check("midrst_status", 5'h0C);
      read_check("midrst_scratch", 5'h04);
      read_check("midrst_chalreg", 5'h10);
      read_check("midrst_resp", 5'h14);
      read_check("midrst_count", 5'h18);
      do_eval("after_rst", 32'h2468_ACE0, 32'hFEED_BEEF, 10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $error("FAIL global_timeout: observed running expected finished");
      $fatal(1, "bench time limit");
   end

endmodule

// File: doc/axil_puf_ctrl.md
# axil_puf_ctrl

AXI4-Lite responder in the PL that the Zynq PS GP master drives to run PUF evaluations. It holds the control, status, challenge and response registers. It sequences a single PUF core through start/done with a timeout, and exposes the captured response to software. It sits between the PS M_AXI_GP0 interconnect port and the PUF core inside the exp-puf-001 block design.

## Interface
- ADDR_WIDTH, 5: byte address width; registers are 32-bit word-aligned.
- VERSION, 32'h0001_0000: value returned by the VERSION register.
- TIMEOUT_CYCLES, 1024: cycles to wait for puf_done before flagging an error; minimum 2.
- s_axi_aclk  in  1  single clock for AXI and PUF side.
- s_axi_areset  in  1  synchronous, active-high reset.
- s_axi_awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  write address channel (awprot ignored).
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response.
- s_axi_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read address.
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data.
- puf_challenge  out  32  challenge, stable from puf_start until puf_done.
- puf_start  out  1  one-cycle start pulse.
- puf_done  in  1  one-cycle completion strobe from the PUF core.
- puf_response  in  32  valid in the cycle puf_done is high.

## Operation
- Register map (byte offset):
  - 0x00 VERSION (RO).
  - 0x04 SCRATCH (RW).
  - 0x08 CONTROL: bit0 START, write-1 pulse, reads 0.
  - 0x0C STATUS: bit0 BUSY (RO); bit1 DONE (sticky, W1C); bit2 TIMEOUT (sticky, W1C).
  - 0x10 CHALLENGE (RW).
  - 0x14 RESPONSE (RO).
  - 0x18 EVAL_COUNT (RO): completed evaluations, 32-bit, wraps 0xFFFF_FFFF to 0.
- wstrb applies per byte to SCRATCH and CHALLENGE. CONTROL and STATUS act only when wstrb[0] is set.
- Addresses above 0x18: writes are discarded with bresp=SLVERR (2'b10). Reads return rdata=0 with rresp=SLVERR. All other accesses return OKAY.
- Write path: AW and W are accepted independently, each held in a one-entry buffer. The register update happens in the cycle both buffers are full. bvalid is held until bready. No new AW or W is accepted while bvalid is high.
- Read path: one outstanding read. arready is high only when rvalid is low. rdata is registered.
- PUF FSM:
  - IDLE: on a START write, latch CHALLENGE into puf_challenge, assert puf_start, go to WAIT, and reset the timeout counter.
  - WAIT: on puf_done, capture puf_response, set DONE, increment EVAL_COUNT and go to IDLE. When the counter reaches TIMEOUT_CYCLES-1 without puf_done, set TIMEOUT, leave RESPONSE unchanged and go to IDLE.
  - BUSY = (state == WAIT).
- START while BUSY is ignored. The CHALLENGE register stays writable while BUSY, but puf_challenge does not change until the next start.
- puf_done in IDLE is ignored.
- If a DONE/TIMEOUT set and a W1C of the same bit fall in the same cycle, the set wins.

## Timing
- Reset values: awready, wready, bvalid, arready, rvalid and puf_start are 0; bresp, rresp and rdata are 0; all registers, puf_challenge and the counter are 0; FSM is in IDLE. arready, awready and wready rise in the first cycle after reset deasserts.
- Write: the register takes its new value on the edge after the later of the AW/W handshakes. bvalid asserts on that same edge.
- Read: rvalid asserts on the edge after the AR handshake, giving 1-cycle latency. A read of a register updated in the same cycle returns the old value.
- puf_start asserts on the edge after the START write commits, so BUSY reads as 1 from that point.
- puf_done sampled at edge N: RESPONSE, DONE and EVAL_COUNT are updated at N, and BUSY is 0 from N.
- Reset during WAIT returns the FSM to IDLE and clears all state, including any pending AXI responses.

## Structure
- Package axil_puf_pkg holds:
  - register offset localparams;
  - STATUS bit indices;
  - RESP_OKAY and RESP_SLVERR;
  - the FSM state enum {IDLE, WAIT}.
- One sub-module, axil_puf_seq, contains the PUF FSM and timeout counter. The top level holds the AXI-Lite channel logic and the register file.

## Test plan
- Post-reset reads: VERSION returns 0x0001_0000 with OKAY; SCRATCH, STATUS and EVAL_COUNT return 0.
- Write SCRATCH=0xDEADBEEF with wstrb=4'b0011, AW issued 3 cycles before W -> single bresp OKAY; readback returns 0x0000BEEF.
- Write CHALLENGE=0x1234_5678 then START; the PUF model returns 0xCAFEF00D after 10 cycles -> puf_start pulses once with puf_challenge=0x1234_5678. STATUS reads 0x1 while busy and 0x2 afterwards. RESPONSE reads 0xCAFEF00D and EVAL_COUNT reads 1.
- Model never asserts puf_done with TIMEOUT_CYCLES=16 -> STATUS reads 0x4 after 16 cycles. RESPONSE is unchanged. Writing 0x4 to STATUS clears it to 0.
- START issued again while BUSY, plus a read of 0x1C -> no second puf_start pulse; the read returns rdata=0 with rresp=SLVERR.
- Preload EVAL_COUNT to 0xFFFF_FFFF via force and run one evaluation -> EVAL_COUNT reads 0.
- Reset asserted mid-WAIT -> BUSY=0 and all registers are 0; a fresh START works normally.
